// File: rtl/tsn_sched_pkg.sv
// -----------------------------------------------------------------------------
// tsn_sched_pkg
// Shared definitions for the transmit scheduler: FSM state encoding, queue-id
// constants, error-bit indices and a small constant helper.
// No ports (package).
// -----------------------------------------------------------------------------
package tsn_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_READ    = 2'd1,
        ST_WAIT_MD = 2'd2,
        ST_WAIT_TX = 2'd3
    } sched_state_t;

    // Queue ids, highest priority first
    localparam logic [1:0] Q_TSN_EVEN = 2'd0;
    localparam logic [1:0] Q_TSN_ODD  = 2'd1;
    localparam logic [1:0] Q_RC_PTP   = 2'd2;
    localparam logic [1:0] Q_BE       = 2'd3;

    // Bit positions within out_ts_err
    localparam int ERR_MD_TIMEOUT = 0;
    localparam int ERR_TX_TIMEOUT = 1;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/prio_enc4.sv
// -----------------------------------------------------------------------------
// prio_enc4
// Combinational strict-priority encoder: q0 beats q1 beats q2 beats q3.
// Ports:
//   eligible [3:0]  in   one bit per queue, 1 = may be served
//   valid           out  at least one queue is eligible
//   qid      [1:0]  out  highest-priority eligible queue (meaningless if !valid)
// -----------------------------------------------------------------------------
module prio_enc4
    import tsn_sched_pkg::*;
(
    input  logic [3:0] eligible,
    output logic       valid,
    output logic [1:0] qid
);

    always_comb begin
        valid = |eligible;
        qid   = Q_BE;
        if (eligible[0]) begin
            qid = Q_TSN_EVEN;
        end else if (eligible[1]) begin
            qid = Q_TSN_ODD;
        end else if (eligible[2]) begin
            qid = Q_RC_PTP;
        end
    end

endmodule

// File: rtl/tx_sched.sv
// -----------------------------------------------------------------------------
// tx_sched
// Transmit-side scheduler. Picks one gate-open, non-empty queue by strict
// priority, pulses its FIFO read enable, captures the returned metadata,
// forwards it to the port transmitter and waits for that frame to finish.
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   in_ts_fifo_empty [3:0]   per-queue FIFO empty flags
//   in_ts_gate_open  [3:0]   per-queue gate state from GC
//   out_ts_q0..q3_rden       one-cycle FIFO read enables (registered)
//   in_ts_md [7:0]           metadata from the buffer
//   in_ts_md_wr              metadata valid, one cycle after a rden
//   out_ts_md [7:0]          captured metadata forwarded to the transmitter
//   out_ts_md_wr             one-cycle valid for out_ts_md / out_ts_qid
//   out_ts_qid [1:0]         queue the forwarded metadata came from
//   in_ts_tx_done            transmitter finished the frame (pulse)
//   out_ts_busy              scheduler is not idle
//   out_ts_err [1:0]         pulses: bit0 metadata timeout, bit1 tx timeout
// -----------------------------------------------------------------------------
module tx_sched
    import tsn_sched_pkg::*;
#(
    parameter int TX_TIMEOUT = 4096,
    parameter int MD_TIMEOUT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] in_ts_fifo_empty,
    input  logic [3:0] in_ts_gate_open,
    output logic       out_ts_q0_rden,
    output logic       out_ts_q1_rden,
    output logic       out_ts_q2_rden,
    output logic       out_ts_q3_rden,
    input  logic [7:0] in_ts_md,
    input  logic       in_ts_md_wr,
    output logic [7:0] out_ts_md,
    output logic       out_ts_md_wr,
    output logic [1:0] out_ts_qid,
    input  logic       in_ts_tx_done,
    output logic       out_ts_busy,
    output logic [1:0] out_ts_err
);

    localparam int CNT_W = $clog2(max_int(TX_TIMEOUT, MD_TIMEOUT)) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    // Timeouts fire on the last allowed cycle so the error pulse lands exactly
    // N cycles after entering the waiting state.
    localparam logic [CNT_W-1:0] MD_LIMIT = CNT_W'(MD_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] TX_LIMIT = CNT_W'((TX_TIMEOUT > 0) ? TX_TIMEOUT - 1 : 0);

    sched_state_t     state_q, state_d;
    logic [1:0]       sel_q, sel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       rden_q, rden_d;
    logic [7:0]       md_q, md_d;
    logic             md_wr_q, md_wr_d;
    logic [1:0]       qid_q, qid_d;
    logic [1:0]       err_q, err_d;

    logic [3:0]       eligible;
    logic             enc_valid;
    logic [1:0]       enc_qid;

    assign eligible = ~in_ts_fifo_empty & in_ts_gate_open;

    prio_enc4 u_prio_enc4 (
        .eligible (eligible),
        .valid    (enc_valid),
        .qid      (enc_qid)
    );

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        rden_d  = '0;
        md_d    = md_q;
        md_wr_d = 1'b0;
        qid_d   = qid_q;
        err_d   = '0;

        case (state_q)
            ST_IDLE: begin
                // Eligibility is only sampled here; once a read is committed
                // later gate/empty changes cannot cancel it.
                if (enc_valid) begin
                    sel_d   = enc_qid;
                    rden_d  = 4'b0001 << enc_qid;
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                state_d = ST_WAIT_MD;
            end
            ST_WAIT_MD: begin
                if (in_ts_md_wr) begin
                    md_d    = in_ts_md;
                    qid_d   = sel_q;
                    md_wr_d = 1'b1;
                    state_d = ST_WAIT_TX;
                end else if (cnt_q >= MD_LIMIT) begin
                    err_d[ERR_MD_TIMEOUT] = 1'b1;
                    state_d               = ST_IDLE;
                end
            end
            ST_WAIT_TX: begin
                // The forwarded-metadata pulse coincides with the first cycle
                // here, so a same-cycle tx_done is naturally accepted.
                if (in_ts_tx_done) begin
                    state_d = ST_IDLE;
                end else if ((TX_TIMEOUT != 0) && (cnt_q >= TX_LIMIT)) begin
                    err_d[ERR_TX_TIMEOUT] = 1'b1;
                    state_d               = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Single shared watchdog: restart on any state change, never wrap.
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            cnt_q   <= '0;
            rden_q  <= '0;
            md_q    <= '0;
            md_wr_q <= 1'b0;
            qid_q   <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            rden_q  <= rden_d;
            md_q    <= md_d;
            md_wr_q <= md_wr_d;
            qid_q   <= qid_d;
            err_q   <= err_d;
        end
    end

    assign out_ts_q0_rden = rden_q[0];
    assign out_ts_q1_rden = rden_q[1];
    assign out_ts_q2_rden = rden_q[2];
    assign out_ts_q3_rden = rden_q[3];
    assign out_ts_md      = md_q;
    assign out_ts_md_wr   = md_wr_q;
    assign out_ts_qid     = qid_q;
    assign out_ts_err     = err_q;
    assign out_ts_busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_tx_sched.sv
// -----------------------------------------------------------------------------
// tb_tx_sched
// Bench for tx_sched. The bench plays the metadata buffer and the port
// transmitter. Whenever the scheduler is free and some queue is eligible, the
// bench plans the whole frame as a timeline of expected events (rden, forwarded
// metadata, error pulse, return to idle) and the response stimulus, then
// compares the DUT outputs against that timeline every cycle.
// -----------------------------------------------------------------------------
module tb_tx_sched;

    localparam int TXT  = 16;
    localparam int MDT  = 4;
    localparam int NCYC = 4096;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] in_ts_fifo_empty;
    logic [3:0] in_ts_gate_open;
    logic       out_ts_q0_rden, out_ts_q1_rden, out_ts_q2_rden, out_ts_q3_rden;
    logic [7:0] in_ts_md;
    logic       in_ts_md_wr;
    logic [7:0] out_ts_md;
    logic       out_ts_md_wr;
    logic [1:0] out_ts_qid;
    logic       in_ts_tx_done;
    logic       out_ts_busy;
    logic [1:0] out_ts_err;

    always #5 clk = ~clk;

    tx_sched #(.TX_TIMEOUT(TXT), .MD_TIMEOUT(MDT)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .in_ts_fifo_empty (in_ts_fifo_empty),
        .in_ts_gate_open  (in_ts_gate_open),
        .out_ts_q0_rden   (out_ts_q0_rden),
        .out_ts_q1_rden   (out_ts_q1_rden),
        .out_ts_q2_rden   (out_ts_q2_rden),
        .out_ts_q3_rden   (out_ts_q3_rden),
        .in_ts_md         (in_ts_md),
        .in_ts_md_wr      (in_ts_md_wr),
        .out_ts_md        (out_ts_md),
        .out_ts_md_wr     (out_ts_md_wr),
        .out_ts_qid       (out_ts_qid),
        .in_ts_tx_done    (in_ts_tx_done),
        .out_ts_busy      (out_ts_busy),
        .out_ts_err       (out_ts_err)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Expected-output timeline and planned stimulus, indexed by cycle
    logic [3:0] e_rden [NCYC];
    logic       e_mdwr [NCYC];
    logic [7:0] e_md   [NCYC];
    logic [1:0] e_qid  [NCYC];
    logic [1:0] e_err  [NCYC];
    logic       d_mdwr [NCYC];
    logic [7:0] d_md   [NCYC];
    logic       d_done [NCYC];

    int         frame_from = 0;
    int         free_at    = 0;
    logic [7:0] held_md;
    logic [1:0] held_qid;

    // Buffer contents per queue
    logic [7:0] fmem [4][64];
    int         fwr [4];
    int         frd [4];
    logic [3:0] gate;

    // md_policy: 0 respond, 1 never respond, 2 random
    // tx_policy: >=0 fixed delay after forwarded md, -1 never, -2 random
    int md_policy;
    int tx_policy;
    logic spur;

    logic [9:0] obsq [$];
    int n_rden [4];
    int n_err0, n_err1;

    task automatic checkVal(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("[TB] FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic checkOutput(input logic [3:0] x_rden, input logic x_mdwr, input logic [7:0] x_md,
                               input logic [1:0] x_qid, input logic [1:0] x_err, input logic x_busy);
        checkVal("rden",  {12'd0, out_ts_q3_rden, out_ts_q2_rden, out_ts_q1_rden, out_ts_q0_rden}, {12'd0, x_rden});
        checkVal("md_wr", {15'd0, out_ts_md_wr}, {15'd0, x_mdwr});
        checkVal("md",    {8'd0, out_ts_md}, {8'd0, x_md});
        checkVal("qid",   {14'd0, out_ts_qid}, {14'd0, x_qid});
        checkVal("err",   {14'd0, out_ts_err}, {14'd0, x_err});
        checkVal("busy",  {15'd0, out_ts_busy}, {15'd0, x_busy});
    endtask

    function automatic int pick(input logic [3:0] elig);
        for (int i = 0; i < 4; i++) begin
            if (elig[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [3:0] empty_vec();
        logic [3:0] e;
        for (int i = 0; i < 4; i++) e[i] = (fwr[i] == frd[i]);
        return e;
    endfunction

    function automatic logic [9:0] obs_at(input int i);
        if (i < obsq.size()) return obsq[i];
        return 10'h3FF;
    endfunction

    task automatic push(input int q, input logic [7:0] d);
        fmem[q][fwr[q] % 64] = d;
        fwr[q]++;
    endtask

    task automatic clear_timeline(input int from);
        for (int i = from; i < NCYC; i++) begin
            e_rden[i] = '0; e_mdwr[i] = 1'b0; e_md[i] = '0; e_qid[i] = '0; e_err[i] = '0;
            d_mdwr[i] = 1'b0; d_md[i] = '0; d_done[i] = 1'b0;
        end
    endtask

    // A frame decided at cycle k: rden at k+1, buffer answers at k+2,
    // forwarded at k+3, then transmitter completion or one of the timeouts.
    task automatic plan_frame(input int k, input int q);
        logic [7:0] data;
        logic       respond;
        int         dly;
        data = fmem[q][frd[q] % 64];
        frd[q]++;
        e_rden[k+1] = 4'b0001 << q;
        frame_from  = k + 1;
        respond = (md_policy == 0) || (md_policy == 2 && $urandom_range(0, 9) != 0);
        if (respond) begin
            d_mdwr[k+2] = 1'b1;
            d_md[k+2]   = data;
            e_mdwr[k+3] = 1'b1;
            e_md[k+3]   = data;
            e_qid[k+3]  = 2'(q);
            if (tx_policy >= 0) dly = tx_policy;
            else if (tx_policy == -1) dly = TXT;
            else dly = $urandom_range(0, 19);
            if (dly < TXT) begin
                d_done[k+3+dly] = 1'b1;
                free_at = k + 3 + dly + 1;
            end else begin
                e_err[k+3+TXT] = 2'b10;
                free_at = k + 3 + TXT;
            end
        end else begin
            e_err[k+2+MDT] = 2'b01;
            free_at = k + 2 + MDT;
        end
    endtask

    task automatic applyStimulus();
        logic [3:0] empty;
        int q;
        empty = empty_vec();
        in_ts_fifo_empty = empty;
        in_ts_gate_open  = gate;
        in_ts_md_wr      = d_mdwr[cyc];
        in_ts_md         = d_mdwr[cyc] ? d_md[cyc] : 8'($urandom);
        in_ts_tx_done    = d_done[cyc];
        if (cyc >= free_at) begin
            if (spur) begin
                in_ts_md_wr   = ($urandom_range(0, 2) == 0);
                in_ts_tx_done = ($urandom_range(0, 2) == 0);
            end
            q = pick(~empty & gate);
            if (q >= 0) plan_frame(cyc, q);
        end
    endtask

    task automatic observe();
        if (out_ts_md_wr) obsq.push_back({out_ts_qid, out_ts_md});
        n_rden[0] += int'(out_ts_q0_rden);
        n_rden[1] += int'(out_ts_q1_rden);
        n_rden[2] += int'(out_ts_q2_rden);
        n_rden[3] += int'(out_ts_q3_rden);
        n_err0 += int'(out_ts_err[0]);
        n_err1 += int'(out_ts_err[1]);
    endtask

    task automatic clear_obs();
        obsq.delete();
        for (int i = 0; i < 4; i++) n_rden[i] = 0;
        n_err0 = 0;
        n_err1 = 0;
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        if (cyc > NCYC - 48) begin
            $display("[TB] FAIL timeline cyc=%0d exceeds limit=%0d", cyc, NCYC - 48);
            $fatal(1, "[TB] out of timeline");
        end
        if (e_mdwr[cyc]) begin
            held_md  = e_md[cyc];
            held_qid = e_qid[cyc];
        end
        checkOutput(e_rden[cyc], e_mdwr[cyc], held_md, held_qid, e_err[cyc],
                    (cyc >= frame_from) && (cyc < free_at));
        observe();
        applyStimulus();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Reset is asserted half a cycle away from the clock edge; outputs must
    // clear without waiting for a clock.
    task automatic doReset(input int hold);
        @(negedge clk);
        cyc++;
        rst_n         = 1'b0;
        in_ts_md_wr   = 1'b0;
        in_ts_tx_done = 1'b0;
        clear_timeline(cyc);
        #1;
        checkOutput(4'b0, 1'b0, 8'h00, 2'd0, 2'b00, 1'b0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            cyc++;
            checkOutput(4'b0, 1'b0, 8'h00, 2'd0, 2'b00, 1'b0);
        end
        held_md    = '0;
        held_qid   = '0;
        free_at    = cyc;
        frame_from = cyc;
        rst_n      = 1'b1;
        applyStimulus();
    endtask

    task automatic drain();
        for (int i = 0; i < 400; i++) begin
            if (cyc >= free_at && empty_vec() == 4'hF) break;
            step();
        end
    endtask

    initial begin
        rst_n            = 1'b0;
        in_ts_fifo_empty = 4'hF;
        in_ts_gate_open  = 4'h0;
        in_ts_md         = 8'h00;
        in_ts_md_wr      = 1'b0;
        in_ts_tx_done    = 1'b0;
        gate      = 4'h0;
        md_policy = 0;
        tx_policy = 3;
        spur      = 1'b0;
        held_md   = '0;
        held_qid  = '0;
        for (int i = 0; i < 4; i++) begin
            fwr[i] = 0;
            frd[i] = 0;
        end
        clear_timeline(0);
        clear_obs();

        doReset(3);

        // Priority: all queues open, q0 and q1 loaded; q0 first, then q1
        gate = 4'b1111;
        push(0, 8'h11);
        push(1, 8'h22);
        run(30);
        checkVal("prio_first",  {6'd0, obs_at(0)}, 16'h0011);
        checkVal("prio_second", {6'd0, obs_at(1)}, 16'h0122);

        // Gating: only q2/q3 open, then everything closed
        clear_obs();
        push(0, 8'h30); push(1, 8'h31); push(2, 8'h32); push(3, 8'h33);
        gate = 4'b1100;
        run(25);
        checkVal("gate_q2", {6'd0, obs_at(0)}, 16'h0232);
        checkVal("gate_q3", {6'd0, obs_at(1)}, 16'h0333);
        clear_obs();
        gate = 4'b0000;
        run(100);
        checkVal("gate_closed_rden", 16'(n_rden[0] + n_rden[1] + n_rden[2] + n_rden[3]), 16'd0);
        gate = 4'b1111;
        drain();

        // Back-to-back from q3 with tx_done 5 cycles after each forward
        clear_obs();
        tx_policy = 5;
        gate = 4'b1000;
        push(3, 8'hA0); push(3, 8'hA1); push(3, 8'hA2);
        run(40);
        checkVal("b2b_rden_q3", 16'(n_rden[3]), 16'd3);
        checkVal("b2b_md0", {6'd0, obs_at(0)}, 16'h03A0);
        checkVal("b2b_md1", {6'd0, obs_at(1)}, 16'h03A1);
        checkVal("b2b_md2", {6'd0, obs_at(2)}, 16'h03A2);

        // Metadata timeout
        clear_obs();
        gate = 4'b1111;
        md_policy = 1;
        push(1, 8'h55);
        run(15);
        checkVal("md_timeout_cnt", 16'(n_err0), 16'd1);
        md_policy = 0;

        // Transmit timeout with spurious tx_done/md_wr while idle
        clear_obs();
        tx_policy = -1;
        spur = 1'b1;
        push(2, 8'h66);
        run(30);
        checkVal("tx_timeout_cnt", 16'(n_err1), 16'd1);
        spur = 1'b0;

        // Reset while waiting for the transmitter, then re-arbitrate
        push(1, 8'h77);
        run(8);
        push(0, 8'h78);
        doReset(2);
        clear_obs();
        tx_policy = 2;
        run(20);
        checkVal("post_reset", {6'd0, obs_at(0)}, 16'h0078);

        // Random traffic
        md_policy = 2;
        tx_policy = -2;
        spur = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                int q;
                q = $urandom_range(0, 3);
                if (fwr[q] - frd[q] < 60) push(q, 8'($urandom));
            end
            if ($urandom_range(0, 15) == 0) gate = 4'($urandom);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
